lsu_data_memory: RTL and testbench

LSU_DATA_MEMORY -- requirements
Module: lsu_data_memory

---
 rtl/lsu_data_memory.sv | 174 +++++++++++++++++
 tb/tb_lsu_data_memory.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_memory.sv
// rtl/lsu_data_memory.sv - byte-addressable LSU data memory with registered loads; DMEM_INIT_CLEAR_EN enables clear-on-reset
module lsu_data_memory #(
    parameter int W     = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic [AW-1:0] address,
    input  logic [2:0]    funct3,
    input  logic [W-1:0]  write_data,
    output logic [W-1:0]  read_data,
    output logic          read_valid,
    output logic          misaligned,
    output logic          busy
);

    localparam int IW = AW - 2;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0]  mem [DEPTH];
    logic [IW-1:0] word_idx;
    logic [1:0]    offset;
    logic [W-1:0]  word_rd;

    logic          load_ok;
    logic          store_ok;
    logic          align_ok;
    logic          active;
    logic          do_store;
    logic          store_mis;
    logic          do_load;
    logic          load_mis;
    logic [3:0]    lane_en;
    logic [W-1:0]  lane_data;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic [W-1:0]  load_val;

    assign word_idx = address[AW-1:2];
    assign offset   = address[1:0];
    assign word_rd  = mem[word_idx];
    assign active   = (state == IDLE);
    assign busy     = (state == INIT);

`ifdef DMEM_INIT_CLEAR_EN
    localparam logic [IW-1:0] LAST_WORD = IW'(DEPTH - 1);

    logic [IW-1:0] clear_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            clear_cnt <= '0;
        end else if (state == INIT) begin
            clear_cnt <= clear_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        if (state == INIT && clear_cnt == LAST_WORD) begin
            state_next = IDLE;
        end
    end
`else
    always_comb begin
        state_next = IDLE;
    end
`endif

    // Size/sign decode and alignment; funct3[1:0] encodes the access size.
    always_comb begin
        load_ok  = 1'b0;
        store_ok = 1'b0;
        align_ok = 1'b1;
        case (funct3)
            3'b000, 3'b001, 3'b010: begin
                load_ok  = 1'b1;
                store_ok = 1'b1;
            end
            3'b100, 3'b101: load_ok = 1'b1;
            default: ;
        endcase
        case (funct3[1:0])
            2'b01:   align_ok = ~offset[0];
            2'b10:   align_ok = (offset == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    assign do_store  = active & MemWrite & store_ok & align_ok;
    assign store_mis = active & MemWrite & store_ok & ~align_ok;
    assign do_load   = active & MemRead & ~MemWrite;
    assign load_mis  = do_load & load_ok & ~align_ok;

    always_comb begin
        lane_en   = 4'b0000;
        lane_data = write_data;
        case (funct3[1:0])
            2'b00: begin
                lane_en[offset] = 1'b1;
                lane_data       = {4{write_data[7:0]}};
            end
            2'b01: begin
                lane_en[{offset[1], 1'b0}] = 1'b1;
                lane_en[{offset[1], 1'b1}] = 1'b1;
                lane_data                  = {2{write_data[15:0]}};
            end
            2'b10:   lane_en = 4'hF;
            default: ;
        endcase
    end

    always_comb begin
        byte_val = 8'(word_rd >> {offset, 3'b000});
        half_val = 16'(word_rd >> {offset[1], 4'b0000});
        load_val = '0;
        case (funct3)
            3'b000:  load_val = {{(W-8){byte_val[7]}}, byte_val};
            3'b001:  load_val = {{(W-16){half_val[15]}}, half_val};
            3'b010:  load_val = word_rd;
            3'b100:  load_val = {{(W-8){1'b0}}, byte_val};
            3'b101:  load_val = {{(W-16){1'b0}}, half_val};
            default: load_val = '0;
        endcase
        if (!align_ok) begin
            load_val = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= INIT;
            read_data  <= '0;
            read_valid <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_next;
            read_valid <= do_load;
            misaligned <= load_mis | store_mis;
            if (do_load) begin
                read_data <= load_val;
            end
        end
    end

    // Clear writes and stores are mutually exclusive: stores only happen in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef DMEM_INIT_CLEAR_EN
            if (state == INIT) begin
                mem[clear_cnt] <= '0;
            end
`endif
            if (do_store) begin
                for (int i = 0; i < 4; i++) begin
                    if (lane_en[i]) begin
                        mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_data_memory.sv
// tb/tb_lsu_data_memory.sv - scoreboard bench for lsu_data_memory with a byte-array reference model
module tb_lsu_data_memory;

    localparam int W     = 32;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH) + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          MemRead = 1'b0;
    logic          MemWrite = 1'b0;
    logic [AW-1:0] address = '0;
    logic [2:0]    funct3 = 3'b000;
    logic [W-1:0]  write_data = '0;
    logic [W-1:0]  read_data;
    logic          read_valid;
    logic          misaligned;
    logic          busy;

    lsu_data_memory #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .funct3     (funct3),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .misaligned (misaligned),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rv;
        bit          mis;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          ntests = 0;
    int          nfail  = 0;
    int          cyc    = 0;
    logic        rst_q  = 1'b0;
    logic [31:0] last_rd = '0;
    logic [7:0]  mdl [DEPTH*4];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: little-endian byte array, natural alignment by access size.
    task automatic issue(input bit rd, input bit wr, input int addr, input logic [2:0] f3,
                         input logic [31:0] wd);
        exp_t        e;
        int          size;
        logic [31:0] v;
        @(negedge clk);
        MemRead    = rd;
        MemWrite   = wr;
        address    = AW'(addr);
        funct3     = f3;
        write_data = wd;
        e.rv   = 1'b0;
        e.mis  = 1'b0;
        e.data = '0;
        e.cyc  = cyc + 1;
        size   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (wr) begin
            if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) begin
                if (addr % size != 0) e.mis = 1'b1;
                else for (int i = 0; i < size; i++) mdl[addr + i] = wd[8*i +: 8];
            end
        end else if (rd) begin
            e.rv = 1'b1;
            if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                if (addr % size != 0) begin
                    e.mis = 1'b1;
                end else begin
                    v = '0;
                    for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[addr + i];
                    if (!f3[2] && size < 4 && v[8*size-1])
                        v = v | ~((32'd1 << (8*size)) - 32'd1);
                    e.data = v;
                end
            end
        end
        if (e.rv || e.mis) q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic zero_fill();
        for (int w = 0; w < DEPTH; w++) issue(1'b0, 1'b1, w*4, 3'd2, 32'h0);
    endtask

    // Releases reset while a store is held on the inputs and counts busy cycles.
    task automatic release_init(input int exp_busy);
        int cnt;
        @(negedge clk);
        rst        = 1'b1;
        MemWrite   = 1'b1;
        MemRead    = 1'b0;
        address    = '0;
        funct3     = 3'd2;
        write_data = 32'hFFFF_FFFF;
        cnt = 0;
        while (busy && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        MemWrite = 1'b0;
        check("busy_cycles", cnt, exp_busy);
`ifdef DMEM_INIT_CLEAR_EN
        for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h00;
`endif
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_q) last_rd = '0;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                ntests++;
                nfail++;
                $display("FAIL missing_pulse: no output seen at cycle %0d, expected rv=%0d mis=%0d", e.cyc, e.rv, e.mis);
            end
            if (read_valid || misaligned) begin
                if (q.size() == 0) begin
                    ntests++;
                    nfail++;
                    $display("FAIL unexpected_pulse: rv=%0d mis=%0d, expected none (cycle %0d)", read_valid, misaligned, cyc);
                end else begin
                    e = q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("read_valid", {31'b0, read_valid}, {31'b0, e.rv});
                    check("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
                    if (e.rv) begin
                        check("read_data", read_data, e.data);
                        last_rd = e.data;
                    end
                end
            end
            if (!read_valid) check("read_data_hold", read_data, last_rd);
        end
    end

    initial begin : timeout
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int          addr;
        logic [2:0]  f3;
        int          r;
        logic [2:0]  f3_list [5];
        f3_list[0] = 3'd0; f3_list[1] = 3'd1; f3_list[2] = 3'd2;
        f3_list[3] = 3'd4; f3_list[4] = 3'd5;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read_data", read_data, 32'h0);
        check("rst_read_valid", {31'b0, read_valid}, 32'h0);
        check("rst_misaligned", {31'b0, misaligned}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h1);

`ifdef DMEM_INIT_CLEAR_EN
        release_init(DEPTH);
`else
        release_init(1);
        zero_fill();
`endif
        for (int w = 0; w < DEPTH; w++) issue(1'b1, 1'b0, w*4, 3'd2, 32'h0);

        issue(1'b0, 1'b1, 'h10, 3'd2, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 'h10, 3'd0, 32'h0);
        issue(1'b1, 1'b0, 'h13, 3'd4, 32'h0);
        issue(1'b1, 1'b0, 'h12, 3'd1, 32'h0);
        issue(1'b1, 1'b0, 'h10, 3'd5, 32'h0);
        issue(1'b0, 1'b1, 'h20, 3'd2, 32'h1122_3344);
        issue(1'b0, 1'b1, 'h21, 3'd0, 32'h0000_00AA);
        issue(1'b0, 1'b1, 'h22, 3'd1, 32'h0000_5566);
        issue(1'b1, 1'b0, 'h20, 3'd2, 32'h0);
        issue(1'b1, 1'b0, 'h22, 3'd2, 32'h0);
        issue(1'b0, 1'b1, 'h05, 3'd1, 32'h0000_FFFF);
        issue(1'b1, 1'b0, 'h04, 3'd2, 32'h0);
        issue(1'b1, 1'b1, 'h08, 3'd2, 32'h1234_5678);
        issue(1'b1, 1'b0, 'h08, 3'd2, 32'h0);
        issue(1'b1, 1'b0, 'h08, 3'd3, 32'h0);
        issue(1'b0, 1'b1, 'h08, 3'd4, 32'hFFFF_FFFF);
        issue(1'b0, 1'b1, 'h08, 3'd7, 32'hFFFF_FFFF);
        issue(1'b1, 1'b0, 'h08, 3'd2, 32'h0);
        issue(1'b1, 1'b0, 'h09, 3'd6, 32'h0);
        idle();
        idle();

        for (int n = 0; n < 400; n++) begin
            r    = $urandom_range(0, 9);
            addr = $urandom_range(0, DEPTH*4 - 1);
            if ($urandom_range(0, 3) != 0) addr = addr & ~3;
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = f3_list[$urandom_range(0, 4)];
            if (r < 4)       issue(1'b1, 1'b0, addr, f3, $urandom);
            else if (r < 8)  issue(1'b0, 1'b1, addr, f3, $urandom);
            else if (r == 8) issue(1'b1, 1'b1, addr, f3, $urandom);
            else             idle();
        end
        idle();
        repeat (3) @(negedge clk);

        rst        = 1'b0;
        MemWrite   = 1'b1;
        address    = AW'(8'h10);
        funct3     = 3'd2;
        write_data = 32'h0BAD_F00D;
        @(negedge clk);
        MemWrite = 1'b0;
        check("rst2_read_data", read_data, 32'h0);
        check("rst2_busy", {31'b0, busy}, 32'h1);

`ifdef DMEM_INIT_CLEAR_EN
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_init_busy", {31'b0, busy}, 32'h1);
        rst = 1'b0;
        release_init(DEPTH);
`else
        release_init(1);
        zero_fill();
`endif
        issue(1'b1, 1'b0, 'h10, 3'd2, 32'h0);
        issue(1'b1, 1'b0, 'h20, 3'd2, 32'h0);
        issue(1'b1, 1'b0, 'hFC, 3'd2, 32'h0);
        issue(1'b0, 1'b1, 'h3C, 3'd2, 32'hCAFE_F00D);
        issue(1'b1, 1'b0, 'h3C, 3'd2, 32'h0);
        issue(1'b1, 1'b0, 'h3E, 3'd0, 32'h0);
        idle();
        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
